// File: rtl/scan_idx_gen.sv
// Channel index sequencer for a 3-to-8 decoder: steps through the active channel set at a
// programmable dwell rate. Define SCAN_BLANK_GAP_EN to insert one blanking cycle per step.
module scan_idx_gen #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic [2:0]            last_idx,
  input  logic [7:0]            ch_mask,
  input  logic [1:0]            mode,
  output logic [2:0]            idx_o,
  output logic                  idx_valid,
  output logic                  step_pulse,
  output logic                  wrap_pulse
);

  typedef enum logic [1:0] {
    ModeUp   = 2'b00,
    ModeDown = 2'b01,
    ModePing = 2'b10,
    ModeHold = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // {found, index} of the smallest set member strictly above org.
  function automatic logic [3:0] find_above(input logic [7:0] set, input logic [2:0] org);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (set[i] && (i > int'(org))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // {found, index} of the largest set member strictly below org.
  function automatic logic [3:0] find_below(input logic [7:0] set, input logic [2:0] org);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 0; i < 8; i++) begin
      if (set[i] && (i < int'(org))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] set);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (set[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [2:0] highest(input logic [7:0] set);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (set[i]) r = 3'(i);
    end
    return r;
  endfunction

  mode_e                 mode_in, mode_q;
  dir_e                  dir_q, dir_d, dir_eff, nxt_dir;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  tick;
  logic [2:0]            idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  step_q, step_d;
  logic                  wrap_q, wrap_d;
  logic [7:0]            act;
  logic                  act_any, act_single;
  logic [3:0]            up_r, dn_r;
  logic [2:0]            nxt;
  logic                  nxt_wrap;
  logic                  busy;
  logic                  step_req;

  assign mode_in = mode_e'(mode);

  always_comb begin
    act = 8'd0;
    for (int i = 0; i < 8; i++) begin
      act[i] = ch_mask[i] && (3'(i) <= last_idx);
    end
  end

  assign act_any    = |act;
  assign act_single = act_any && ((act & (act - 8'd1)) == 8'd0);

  // Prescaler: >= rather than == so a lowered div cannot strand the count above it.
  always_comb begin
    tick  = en && (cnt_q >= div);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  // Entering ping-pong inherits the direction of the mode it came from.
  always_comb begin
    dir_eff = dir_q;
    if ((mode_in == ModePing) && (mode_q != ModePing)) begin
      dir_eff = (mode_q == ModeDown) ? DirDown : DirUp;
    end
  end

  assign up_r = find_above(act, idx_q);
  assign dn_r = find_below(act, idx_q);

  always_comb begin
    nxt      = idx_q;
    nxt_wrap = 1'b0;
    nxt_dir  = dir_eff;
    unique case (mode_in)
      ModeUp: begin
        if (up_r[3]) begin
          nxt = up_r[2:0];
        end else begin
          nxt      = lowest(act);
          nxt_wrap = 1'b1;
        end
      end
      ModeDown: begin
        if (dn_r[3]) begin
          nxt = dn_r[2:0];
        end else begin
          nxt      = highest(act);
          nxt_wrap = 1'b1;
        end
      end
      ModePing: begin
        if (dir_eff == DirUp) begin
          if (up_r[3]) begin
            nxt = up_r[2:0];
          end else begin
            nxt_dir  = DirDown;
            nxt      = dn_r[3] ? dn_r[2:0] : highest(act);
            nxt_wrap = 1'b1;
          end
        end else begin
          if (dn_r[3]) begin
            nxt = dn_r[2:0];
          end else begin
            nxt_dir  = DirUp;
            nxt      = up_r[3] ? up_r[2:0] : lowest(act);
            nxt_wrap = 1'b1;
          end
        end
      end
      ModeHold: ;
      default: ;
    endcase
    // A single active channel is its own wrap point on every tick.
    if (act_single) nxt_wrap = 1'b1;
  end

  assign step_req = tick && act_any && (mode_in != ModeHold) && !busy;

  always_comb begin
    dir_d = dir_q;
    if (mode_in == ModePing) begin
      dir_d = step_req ? nxt_dir : dir_eff;
    end
  end

`ifdef SCAN_BLANK_GAP_EN
  logic       pend_q, pend_d;
  logic [2:0] pend_idx_q, pend_idx_d;
  logic       pend_wrap_q, pend_wrap_d;

  assign busy = pend_q;

  // Tick edge blanks the output; the following edge commits the new index and pulses.
  always_comb begin
    idx_d       = idx_q;
    step_d      = 1'b0;
    wrap_d      = 1'b0;
    pend_d      = 1'b0;
    pend_idx_d  = pend_idx_q;
    pend_wrap_d = pend_wrap_q;
    valid_d     = en && act[idx_q];
    if (pend_q) begin
      idx_d   = pend_idx_q;
      step_d  = 1'b1;
      wrap_d  = pend_wrap_q;
      valid_d = en && act[pend_idx_q];
    end else if (step_req) begin
      pend_d      = 1'b1;
      pend_idx_d  = nxt;
      pend_wrap_d = nxt_wrap;
      valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_idx_q  <= 3'd0;
      pend_wrap_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      pend_wrap_q <= pend_wrap_d;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    idx_d  = idx_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (step_req) begin
      idx_d  = nxt;
      step_d = 1'b1;
      wrap_d = nxt_wrap;
    end
    valid_d = en && act[idx_d];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dir_q   <= DirUp;
      mode_q  <= ModeUp;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
      mode_q  <= mode_in;
    end
  end

  assign idx_o      = idx_q;
  assign idx_valid  = valid_q;
  assign step_pulse = step_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_scan_idx_gen.sv
// Directed bench for scan_idx_gen; expected sequences are hand-computed per scenario.
module tb_scan_idx_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic [2:0]  last_idx;
  logic [7:0]  ch_mask;
  logic [1:0]  mode;
  logic [2:0]  idx_o;
  logic        idx_valid;
  logic        step_pulse;
  logic        wrap_pulse;

  int n_vec = 0;
  int n_bad = 0;

  scan_idx_gen #(.PRESCALE_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div        (div),
    .last_idx   (last_idx),
    .ch_mask    (ch_mask),
    .mode       (mode),
    .idx_o      (idx_o),
    .idx_valid  (idx_valid),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; div = 16'd0; last_idx = 3'd7; ch_mask = 8'hFF; mode = 2'b00;
    edge_step();
    edge_step();
    n_vec++; if (idx_o !== 3'd0) begin n_bad++; $display("FAIL reset_idx got %0d exp 0", idx_o); end
    n_vec++; if (idx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", idx_valid); end
    n_vec++; if (step_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_step got %b exp 0", step_pulse); end
    n_vec++; if (wrap_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b exp 0", wrap_pulse); end
  endtask

`ifdef SCAN_BLANK_GAP_EN
  task automatic test_blank_gap();
    logic [2:0] ei;
    logic       ev;
    div = 16'd1; mode = 2'b00; ch_mask = 8'hFF; last_idx = 3'd7;
    rst_n = 1'b1; en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      edge_step();
      if (e == 1) begin
        ei = 3'd0; ev = 1'b1;
      end else if (e % 2 == 0) begin
        ei = 3'((e / 2) - 1); ev = 1'b0;
      end else begin
        ei = 3'((e - 1) / 2); ev = 1'b1;
      end
      n_vec++; if (idx_o !== ei) begin n_bad++; $display("FAIL gap_idx e=%0d got %0d exp %0d", e, idx_o, ei); end
      n_vec++; if (idx_valid !== ev) begin n_bad++; $display("FAIL gap_valid e=%0d got %b exp %b", e, idx_valid, ev); end
      n_vec++; if (step_pulse !== (e > 1 && e % 2 == 1)) begin n_bad++; $display("FAIL gap_step e=%0d got %b", e, step_pulse); end
    end
  endtask
`else
  task automatic test_up();
    rst_n = 1'b1; en = 1'b1;
    n_vec++; if (idx_o !== 3'd0) begin n_bad++; $display("FAIL up_start got %0d exp 0", idx_o); end
    for (int e = 1; e <= 8; e++) begin
      edge_step();
      n_vec++; if (idx_o !== 3'(e % 8)) begin n_bad++; $display("FAIL up_idx e=%0d got %0d exp %0d", e, idx_o, e % 8); end
      n_vec++; if (idx_valid !== 1'b1) begin n_bad++; $display("FAIL up_valid e=%0d got %b exp 1", e, idx_valid); end
      n_vec++; if (step_pulse !== 1'b1) begin n_bad++; $display("FAIL up_step e=%0d got %b exp 1", e, step_pulse); end
      n_vec++; if (wrap_pulse !== (e == 8)) begin n_bad++; $display("FAIL up_wrap e=%0d got %b exp %b", e, wrap_pulse, e == 8); end
    end
  endtask

  task automatic test_down();
    logic [2:0] seq [8];
    int n;
    seq = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    div = 16'd3; mode = 2'b01; ch_mask = 8'hFF; last_idx = 3'd5;
    for (int e = 1; e <= 28; e++) begin
      edge_step();
      n = e / 4;
      n_vec++; if (idx_o !== seq[n]) begin n_bad++; $display("FAIL down_idx e=%0d got %0d exp %0d", e, idx_o, seq[n]); end
      n_vec++; if (step_pulse !== (e % 4 == 0)) begin n_bad++; $display("FAIL down_step e=%0d got %b", e, step_pulse); end
      n_vec++; if (wrap_pulse !== (e == 4 || e == 28)) begin n_bad++; $display("FAIL down_wrap e=%0d got %b", e, wrap_pulse); end
    end
  endtask

  task automatic test_mode_switch();
    logic [2:0] seq [2];
    seq = '{3'd4, 3'd3};
    div = 16'd0; mode = 2'b10; ch_mask = 8'hFF; last_idx = 3'd7;
    for (int e = 0; e < 2; e++) begin
      edge_step();
      n_vec++; if (idx_o !== seq[e]) begin n_bad++; $display("FAIL sw_idx e=%0d got %0d exp %0d", e, idx_o, seq[e]); end
      n_vec++; if (wrap_pulse !== 1'b0) begin n_bad++; $display("FAIL sw_wrap e=%0d got %b exp 0", e, wrap_pulse); end
    end
  endtask

  task automatic test_pingpong();
    logic [2:0] seq [7];
    logic       wr  [7];
    seq = '{3'd2, 3'd3, 3'd5, 3'd3, 3'd2, 3'd0, 3'd2};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; div = 16'd0; mode = 2'b10; ch_mask = 8'b0010_1101; last_idx = 3'd7;
    edge_step();
    n_vec++; if (idx_o !== 3'd0) begin n_bad++; $display("FAIL pp_start got %0d exp 0", idx_o); end
    rst_n = 1'b1;
    for (int e = 0; e < 7; e++) begin
      edge_step();
      n_vec++; if (idx_o !== seq[e]) begin n_bad++; $display("FAIL pp_idx e=%0d got %0d exp %0d", e, idx_o, seq[e]); end
      n_vec++; if (wrap_pulse !== wr[e]) begin n_bad++; $display("FAIL pp_wrap e=%0d got %b exp %b", e, wrap_pulse, wr[e]); end
      n_vec++; if (step_pulse !== 1'b1) begin n_bad++; $display("FAIL pp_step e=%0d got %b exp 1", e, step_pulse); end
    end
  endtask

  task automatic test_empty_mask();
    ch_mask = 8'h00; mode = 2'b00;
    for (int e = 0; e < 3; e++) begin
      edge_step();
      n_vec++; if (idx_o !== 3'd2) begin n_bad++; $display("FAIL empty_idx e=%0d got %0d exp 2", e, idx_o); end
      n_vec++; if (idx_valid !== 1'b0) begin n_bad++; $display("FAIL empty_valid e=%0d got %b exp 0", e, idx_valid); end
      n_vec++; if ({step_pulse, wrap_pulse} !== 2'b00) begin n_bad++; $display("FAIL empty_pulse e=%0d got %b%b exp 00", e, step_pulse, wrap_pulse); end
    end
    ch_mask = 8'h10;
    for (int e = 0; e < 2; e++) begin
      edge_step();
      n_vec++; if (idx_o !== 3'd4) begin n_bad++; $display("FAIL single_idx e=%0d got %0d exp 4", e, idx_o); end
      n_vec++; if (idx_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid e=%0d got %b exp 1", e, idx_valid); end
      n_vec++; if ({step_pulse, wrap_pulse} !== 2'b11) begin n_bad++; $display("FAIL single_pulse e=%0d got %b%b exp 11", e, step_pulse, wrap_pulse); end
    end
  endtask

  task automatic test_lower_last();
    ch_mask = 8'hFF; last_idx = 3'd7; mode = 2'b00; div = 16'd0;
    edge_step();
    edge_step();
    n_vec++; if (idx_o !== 3'd6) begin n_bad++; $display("FAIL last_pre got %0d exp 6", idx_o); end
    div = 16'd3; last_idx = 3'd3;
    for (int e = 1; e <= 3; e++) begin
      edge_step();
      n_vec++; if (idx_o !== 3'd6) begin n_bad++; $display("FAIL last_hold e=%0d got %0d exp 6", e, idx_o); end
      n_vec++; if (idx_valid !== 1'b0) begin n_bad++; $display("FAIL last_valid e=%0d got %b exp 0", e, idx_valid); end
      n_vec++; if (step_pulse !== 1'b0) begin n_bad++; $display("FAIL last_step e=%0d got %b exp 0", e, step_pulse); end
    end
    edge_step();
    n_vec++; if (idx_o !== 3'd0) begin n_bad++; $display("FAIL last_move got %0d exp 0", idx_o); end
    n_vec++; if (idx_valid !== 1'b1) begin n_bad++; $display("FAIL last_valid2 got %b exp 1", idx_valid); end
    n_vec++; if ({step_pulse, wrap_pulse} !== 2'b11) begin n_bad++; $display("FAIL last_pulse got %b%b exp 11", step_pulse, wrap_pulse); end
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e < 4; e++) edge_step();
    n_vec++; if (idx_o !== 3'd1) begin n_bad++; $display("FAIL rmid_pre got %0d exp 1", idx_o); end
    edge_step();
    edge_step();
    rst_n = 1'b0;
    edge_step();
    n_vec++; if (idx_o !== 3'd0) begin n_bad++; $display("FAIL rmid_idx got %0d exp 0", idx_o); end
    n_vec++; if ({idx_valid, step_pulse, wrap_pulse} !== 3'b000) begin n_bad++; $display("FAIL rmid_flags got %b%b%b exp 000", idx_valid, step_pulse, wrap_pulse); end
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      edge_step();
      n_vec++; if (idx_o !== ((e == 4) ? 3'd1 : 3'd0)) begin n_bad++; $display("FAIL rmid_run_idx e=%0d got %0d", e, idx_o); end
      n_vec++; if (step_pulse !== (e == 4)) begin n_bad++; $display("FAIL rmid_run_step e=%0d got %b", e, step_pulse); end
      n_vec++; if (idx_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_run_valid e=%0d got %b exp 1", e, idx_valid); end
    end
  endtask

  task automatic test_hold_and_enable();
    div = 16'd0; mode = 2'b11;
    for (int e = 0; e < 3; e++) begin
      edge_step();
      n_vec++; if (idx_o !== 3'd1) begin n_bad++; $display("FAIL hold_idx e=%0d got %0d exp 1", e, idx_o); end
      n_vec++; if ({idx_valid, step_pulse, wrap_pulse} !== 3'b100) begin n_bad++; $display("FAIL hold_flags e=%0d got %b%b%b exp 100", e, idx_valid, step_pulse, wrap_pulse); end
    end
    mode = 2'b00; en = 1'b0;
    for (int e = 0; e < 2; e++) begin
      edge_step();
      n_vec++; if (idx_o !== 3'd1) begin n_bad++; $display("FAIL dis_idx e=%0d got %0d exp 1", e, idx_o); end
      n_vec++; if ({idx_valid, step_pulse} !== 2'b00) begin n_bad++; $display("FAIL dis_flags e=%0d got %b%b exp 00", e, idx_valid, step_pulse); end
    end
    en = 1'b1;
    edge_step();
    n_vec++; if (idx_o !== 3'd2) begin n_bad++; $display("FAIL reen_idx got %0d exp 2", idx_o); end
    n_vec++; if ({idx_valid, step_pulse} !== 2'b11) begin n_bad++; $display("FAIL reen_flags got %b%b exp 11", idx_valid, step_pulse); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b0; div = 16'd0; last_idx = 3'd7; ch_mask = 8'hFF; mode = 2'b00;
    test_reset();
`ifdef SCAN_BLANK_GAP_EN
    test_blank_gap();
`else
    test_up();
    test_down();
    test_mode_switch();
    test_pingpong();
    test_empty_mask();
    test_lower_last();
    test_reset_mid();
    test_hold_and_enable();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
